imm_gen_pipe: RTL and testbench

Parametrised, pipelined immediate generator for the decode stage, replacing the single-cycle combinational immediate extractor. It decodes every RV32I/RV64I immediate format: I, S, B, U (both LUI and AUIPC), J, CSR zimm and shift-amount. It sign-extends to XLEN and computes the PC-relative target for B/J/AUIPC. Decode-to-output path uses a valid/ready handshake with a 2-entry skid buffer, giving full throughput and a registered in_ready_o.

---
 rtl/imm_gen_pipe.sv | 133 +++++++++++++
 tb/tb_imm_gen_pipe.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator: decodes every immediate format, sign-extends it
// to XLEN and forms the PC-relative target, behind a valid/ready stage with a skid entry.
module imm_gen_pipe #(
  parameter int unsigned XLEN     = 32,
  parameter bit          RV64_OPS = 1'b0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fmt_o,
  output logic [XLEN-1:0] target_o,
  output logic            pc_rel_o,
  output logic            illegal_o,
  output logic            out_valid_o,
  input  logic            out_ready_i
);

  localparam logic [2:0] FmtNone = 3'd0;
  localparam logic [2:0] FmtI    = 3'd1;
  localparam logic [2:0] FmtS    = 3'd2;
  localparam logic [2:0] FmtB    = 3'd3;
  localparam logic [2:0] FmtU    = 3'd4;
  localparam logic [2:0] FmtJ    = 3'd5;
  localparam logic [2:0] FmtZ    = 3'd6;
  localparam logic [2:0] FmtSh   = 3'd7;

  localparam bit DecodeW = RV64_OPS && (XLEN == 64);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic [2:0]      fmt;
    logic            pc_rel;
    logic            illegal;
  } beat_t;

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic       w_shift_op;
  beat_t      w_dec;

  assign w_opcode   = instr_i[6:0];
  assign w_funct3   = instr_i[14:12];
  assign w_shift_op = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);

  always_comb begin
    w_dec = '0;
    case (w_opcode)
      7'b0000011, 7'b1100111: w_dec.fmt = FmtI;
      7'b0010011:             w_dec.fmt = w_shift_op ? FmtSh : FmtI;
      7'b0011011:             w_dec.fmt = !DecodeW ? FmtNone : (w_shift_op ? FmtSh : FmtI);
      7'b0100011:             w_dec.fmt = FmtS;
      7'b1100011:             w_dec.fmt = FmtB;
      7'b1101111:             w_dec.fmt = FmtJ;
      7'b0110111, 7'b0010111: w_dec.fmt = FmtU;
      7'b1110011:             w_dec.fmt = instr_i[14] ? FmtZ : FmtNone;
      default:                w_dec.fmt = FmtNone;
    endcase

    case (w_dec.fmt)
      FmtI: w_dec.imm = {{(XLEN-11){instr_i[31]}}, instr_i[30:20]};
      FmtS: w_dec.imm = {{(XLEN-11){instr_i[31]}}, instr_i[30:25], instr_i[11:7]};
      FmtB: w_dec.imm = {{(XLEN-12){instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8],
                         1'b0};
      FmtU: w_dec.imm = {{(XLEN-31){instr_i[31]}}, instr_i[30:12], 12'b0};
      FmtJ: w_dec.imm = {{(XLEN-20){instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21],
                         1'b0};
      FmtZ: w_dec.imm = {{(XLEN-5){1'b0}}, instr_i[19:15]};
      FmtSh: begin
        // 32-bit shifts (RV32 or the *W forms) only have a 5-bit shamt; bit 25 is reserved.
        if ((XLEN == 32) || (w_opcode == 7'b0011011)) begin
          w_dec.imm     = {{(XLEN-5){1'b0}}, instr_i[24:20]};
          w_dec.illegal = instr_i[25];
        end else begin
          w_dec.imm     = {{(XLEN-6){1'b0}}, instr_i[25:20]};
        end
      end
      default: w_dec.imm = '0;
    endcase

    w_dec.pc_rel = (w_dec.fmt == FmtB) || (w_dec.fmt == FmtJ) || (w_opcode == 7'b0010111);
    w_dec.target = w_dec.pc_rel ? (pc_i + w_dec.imm) : '0;
  end

  logic  r_out_valid;
  logic  r_skid_valid;
  beat_t r_out;
  beat_t r_skid;
  logic  w_in_fire;
  logic  w_out_free;

  assign w_in_fire  = in_valid_i & ~r_skid_valid;
  assign w_out_free = ~r_out_valid | out_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_out        <= '0;
      r_skid       <= '0;
    end else if (flush_i) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_free) begin
      // in_ready_o is low whenever the skid holds a beat, so no new beat competes with it here.
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else begin
        r_out_valid <= w_in_fire;
        if (w_in_fire) r_out <= w_dec;
      end
    end else if (w_in_fire) begin
      r_skid       <= w_dec;
      r_skid_valid <= 1'b1;
    end
  end

  assign in_ready_o  = ~r_skid_valid;
  assign out_valid_o = r_out_valid;
  assign imm_o       = r_out.imm;
  assign fmt_o       = r_out.fmt;
  assign target_o    = r_out.target;
  assign pc_rel_o    = r_out.pc_rel;
  assign illegal_o   = r_out.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: an XLEN=32 and an XLEN=64/RV64_OPS instance share one stimulus stream
// and are checked against an arithmetic decode model plus a queue of in-flight beats.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] instr = '0;
  logic [63:0] pc64 = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;

  logic        rdy32, ov32, pcr32, ill32;
  logic [31:0] imm32, tgt32;
  logic [2:0]  fmt32;
  logic        rdy64, ov64, pcr64, ill64;
  logic [63:0] imm64, tgt64;
  logic [2:0]  fmt64;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .RV64_OPS(1'b0)) u_dut32 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .instr_i(instr), .pc_i(pc64[31:0]),
    .in_valid_i(in_valid), .in_ready_o(rdy32), .imm_o(imm32), .fmt_o(fmt32), .target_o(tgt32),
    .pc_rel_o(pcr32), .illegal_o(ill32), .out_valid_o(ov32), .out_ready_i(out_ready)
  );

  imm_gen_pipe #(.XLEN(64), .RV64_OPS(1'b1)) u_dut64 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .instr_i(instr), .pc_i(pc64),
    .in_valid_i(in_valid), .in_ready_o(rdy64), .imm_o(imm64), .fmt_o(fmt64), .target_o(tgt64),
    .pc_rel_o(pcr64), .illegal_o(ill64), .out_valid_o(ov64), .out_ready_i(out_ready)
  );

  typedef struct {
    logic [63:0] imm;
    logic [63:0] tgt;
    logic [2:0]  fmt;
    logic        pcrel;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] ins;
    logic [63:0] pc;
  } beat_t;

  beat_t q[$];

  function automatic exp_t ref_dec(int xlen, bit rv64, logic [31:0] ins, logic [63:0] pc);
    exp_t        e;
    longint      v;
    logic [63:0] mask;
    logic [6:0]  opc;
    logic [2:0]  f3;
    bit          sh;
    opc  = ins[6:0];
    f3   = ins[14:12];
    sh   = (f3 == 3'd1) || (f3 == 3'd5);
    mask = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    e    = '{default: '0};
    v    = 0;
    case (opc)
      7'h03, 7'h67: e.fmt = 3'd1;
      7'h13:        e.fmt = sh ? 3'd7 : 3'd1;
      7'h1B:        e.fmt = !rv64 ? 3'd0 : (sh ? 3'd7 : 3'd1);
      7'h23:        e.fmt = 3'd2;
      7'h63:        e.fmt = 3'd3;
      7'h6F:        e.fmt = 3'd5;
      7'h37, 7'h17: e.fmt = 3'd4;
      7'h73:        e.fmt = ins[14] ? 3'd6 : 3'd0;
      default:      e.fmt = 3'd0;
    endcase
    case (e.fmt)
      3'd1: v = $signed(ins[31:20]);
      3'd2: v = $signed({ins[31:25], ins[11:7]});
      3'd3: v = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
      3'd4: v = $signed({ins[31:12], 12'h000});
      3'd5: v = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
      3'd6: v = longint'(ins[19:15]);
      3'd7: begin
        if (xlen == 32 || opc == 7'h1B) begin
          v     = longint'(ins[24:20]);
          e.ill = ins[25];
        end else begin
          v = longint'(ins[25:20]);
        end
      end
      default: v = 0;
    endcase
    e.imm   = 64'(v) & mask;
    e.pcrel = (e.fmt == 3'd3) || (e.fmt == 3'd5) || (opc == 7'h17);
    e.tgt   = e.pcrel ? ((pc + e.imm) & mask) : 64'd0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive after the falling edge, sample 1 ns before the rising edge, update model.
  task automatic step(input bit v, input bit r, input bit f, input logic [31:0] ins,
                      input logic [63:0] pc, output bit acc);
    int   sz;
    exp_t e32, e64;
    @(negedge clk);
    in_valid  = v;
    out_ready = r;
    flush     = f;
    instr     = ins;
    pc64      = pc;
    #4;
    sz = q.size();
    chk("out_valid32", 64'(ov32), 64'(sz > 0));
    chk("out_valid64", 64'(ov64), 64'(sz > 0));
    chk("in_ready32", 64'(rdy32), 64'(sz < 2));
    chk("in_ready64", 64'(rdy64), 64'(sz < 2));
    acc = v && (sz < 2);
    if (r && sz > 0) begin
      e32 = ref_dec(32, 1'b0, q[0].ins, {32'd0, q[0].pc[31:0]});
      e64 = ref_dec(64, 1'b1, q[0].ins, q[0].pc);
      chk("imm32", 64'(imm32), e32.imm);
      chk("fmt32", 64'(fmt32), 64'(e32.fmt));
      chk("tgt32", 64'(tgt32), e32.tgt);
      chk("pcrel32", 64'(pcr32), 64'(e32.pcrel));
      chk("ill32", 64'(ill32), 64'(e32.ill));
      chk("imm64", imm64, e64.imm);
      chk("fmt64", 64'(fmt64), 64'(e64.fmt));
      chk("tgt64", tgt64, e64.tgt);
      chk("pcrel64", 64'(pcr64), 64'(e64.pcrel));
      chk("ill64", 64'(ill64), 64'(e64.ill));
    end
    if (f) begin
      q.delete();
    end else begin
      if (r && sz > 0) void'(q.pop_front());
      if (acc) q.push_back('{ins: ins, pc: pc});
    end
  endtask

  // Send one beat into an empty pipe and check the registered result one cycle later.
  task automatic directed(input string tag, input logic [31:0] ins, input logic [63:0] pc,
                          input logic [63:0] imm_32, input logic [2:0] fmt_32,
                          input logic [63:0] tgt_32, input logic ill_32,
                          input logic [63:0] imm_64, input logic ill_64);
    bit acc;
    step(1'b1, 1'b1, 1'b0, ins, pc, acc);
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, 64'(ov32), 64'd1);
    chk({tag, "_imm32"}, 64'(imm32), imm_32);
    chk({tag, "_fmt32"}, 64'(fmt32), 64'(fmt_32));
    chk({tag, "_tgt32"}, 64'(tgt32), tgt_32);
    chk({tag, "_ill32"}, 64'(ill32), 64'(ill_32));
    chk({tag, "_imm64"}, imm64, imm_64);
    chk({tag, "_ill64"}, 64'(ill64), 64'(ill_64));
    step(1'b0, 1'b1, 1'b0, 32'd0, 64'd0, acc);
  endtask

  logic [6:0] opc_tbl [10] = '{7'h03, 7'h67, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h6F, 7'h37,
                               7'h17, 7'h73};

  initial begin
    bit          acc;
    int          sent;
    int          cycles;
    int          sel;
    logic [31:0] ins;
    logic [63:0] pc;

    #3;
    chk("rst_out_valid", 64'(ov32), 64'd0);
    chk("rst_in_ready", 64'(rdy32), 64'd1);
    chk("rst_imm", 64'(imm32), 64'd0);
    chk("rst_fmt", 64'(fmt64), 64'd0);
    chk("rst_tgt", tgt64, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    directed("addi", 32'hFFF00093, 64'h0, 64'hFFFF_FFFF, 3'd1, 64'h0, 1'b0,
             64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    chk("addi_pcrel", 64'(pcr32), 64'd0);
    directed("beq", 32'hFE000EE3, 64'h100, 64'hFFFF_FFFC, 3'd3, 64'hFC, 1'b0,
             64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    directed("jal", 32'h0080006F, 64'h200, 64'h8, 3'd5, 64'h208, 1'b0, 64'h8, 1'b0);
    directed("auipc", 32'h12345297, 64'h1000, 64'h1234_5000, 3'd4, 64'h1234_6000, 1'b0,
             64'h1234_5000, 1'b0);
    directed("csrrwi", 32'h000FD0F3, 64'h0, 64'h1F, 3'd6, 64'h0, 1'b0, 64'h1F, 1'b0);
    directed("slli_b25", 32'h02001013, 64'h0, 64'h0, 3'd7, 64'h0, 1'b1, 64'd32, 1'b0);
    directed("lui", 32'h800000B7, 64'h0, 64'h8000_0000, 3'd4, 64'h0, 1'b0,
             64'hFFFF_FFFF_8000_0000, 1'b0);
    directed("slli33", 32'h02101013, 64'h0, 64'h1, 3'd7, 64'h0, 1'b1, 64'd33, 1'b0);
    directed("slliw", 32'h0210101B, 64'h0, 64'h0, 3'd0, 64'h0, 1'b0, 64'h1, 1'b1);
    chk("slliw_fmt64", 64'(fmt64), 64'd7);

    // Back-pressure: 4 beats, consumer stalled for 3 cycles.
    sent = 0;
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 1'b0, 1'b0, 32'h00100093 + (sent << 20), 64'h40 * sent, acc);
      if (c == 2) chk("bp_in_ready_low", 64'(rdy32), 64'd0);
      if (acc) sent++;
    end
    chk("bp_accepted_two", 64'(sent), 64'd2);
    cycles = 0;
    while (sent < 4 && cycles < 20) begin
      step(1'b1, 1'b1, 1'b0, 32'h00100093 + (sent << 20), 64'h40 * sent, acc);
      if (acc) sent++;
      cycles++;
    end
    chk("bp_all_sent", 64'(sent), 64'd4);
    for (int c = 0; c < 4; c++) step(1'b0, 1'b1, 1'b0, 32'd0, 64'd0, acc);
    chk("bp_drained", 64'(q.size()), 64'd0);

    // Flush with both entries full while a marker beat is presented.
    step(1'b1, 1'b0, 1'b0, 32'h00A00093, 64'h0, acc);
    step(1'b1, 1'b0, 1'b0, 32'h00B00093, 64'h0, acc);
    step(1'b1, 1'b1, 1'b1, 32'h7FF00093, 64'h0, acc);
    @(posedge clk);
    #1;
    chk("flush_out_valid", 64'(ov32), 64'd0);
    chk("flush_in_ready", 64'(rdy64), 64'd1);
    for (int c = 0; c < 3; c++) step(1'b0, 1'b1, 1'b0, 32'd0, 64'd0, acc);

    // Asynchronous reset while stalled with both entries full.
    step(1'b1, 1'b0, 1'b0, 32'hFFF00093, 64'h0, acc);
    step(1'b1, 1'b0, 1'b0, 32'h0080006F, 64'h300, acc);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(ov64), 64'd0);
    chk("arst_in_ready", 64'(rdy32), 64'd1);
    chk("arst_imm", imm64, 64'd0);
    chk("arst_tgt", 64'(tgt32), 64'd0);
    chk("arst_fmt", 64'(fmt32), 64'd0);
    chk("arst_pcrel", 64'(pcr64), 64'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;

    // Randomised traffic against the model queue.
    sent   = 0;
    cycles = 0;
    ins    = '0;
    pc     = '0;
    acc    = 1'b1;
    while (sent < 10000 && cycles < 60000) begin
      if (acc) begin
        sel = $urandom_range(0, 10);
        ins = $urandom;
        if (sel < 10) ins[6:0] = opc_tbl[sel];
        pc  = {$urandom, $urandom};
      end
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 199) == 0), ins, pc, acc);
      if (acc) sent++;
      cycles++;
    end
    chk("rand_beats_done", 64'(sent), 64'd10000);
    for (int c = 0; c < 4; c++) step(1'b0, 1'b1, 1'b0, 32'd0, 64'd0, acc);
    chk("rand_drained", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
